pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

- Drives the enable, clear and stall controls of the four inter-stage pipeline registers (IF/ID, ID/EX, EX/DM, DM/WB) and the PC write enable of the 5-stage core.
- Detects three conditions and emits the per-stage control pattern for each:
  - load-use hazards, handled with a bubble plus a stall;
  - taken-branch redirects, handled with a flush;
  - data-memory wait, handled with a full freeze.
- Runs a RUN/HALTED/RESUME state machine: a halt reaching WB freezes the core until an external resume.
- Keeps cycle, stall and flush performance counters.

## Interface
Parameters:
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  core clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- id_rs, id_rt  in  5 each  source register numbers of the instruction in ID.
- id_uses_rs, id_uses_rt  in  1 each  the ID instruction actually reads rs / rt.
- ex_mem_read  in  1  the instruction in EX is a load.
- ex_req_w  in  5  destination register of the instruction in EX.
- ex_branch_taken  in  1  the EX stage redirects the PC this cycle.
- dm_busy  in  1  data memory not ready; the pipeline must hold.
- wb_halt  in  1  halt flag from the DM/WB register output.
- resume  in  1  single-cycle pulse; leave HALTED.
- pc_en  out  1  PC write enable.
- if_id_en, id_ex_en, ex_dm_en, dm_wb_en  out  1 each  stage register enables.
- if_id_clr, id_ex_clr, ex_dm_clr, dm_wb_clr  out  1 each  stage register clears, **active-low** (0 clears at the next edge).
- if_id_stall  out  1  IF/ID hold request.
- halted  out  1  high while in HALTED.
- cycle_cnt, stall_cnt, flush_cnt  out  CNT_W each  performance counters.

## Operation
Defaults (no event): all enables = 1, all clr = 1, if_id_stall = 0, pc_en = 1.

Load-use hazard, `lu`:
- `lu` = ex_mem_read & ex_req_w≠0 & ((id_uses_rs & id_rs==ex_req_w) | (id_uses_rt & id_rt==ex_req_w)).
- Response: pc_en=0, if_id_stall=1, id_ex_clr=0 (bubble). Later stages advance.

Branch flush, `br`:
- `br` = ex_branch_taken.
- Response: if_id_clr=0, id_ex_clr=0, pc_en=1.
- `br` has priority over `lu`: when both are true, apply the `br` pattern only and do not count a stall.

Memory wait, `dm_busy` in RUN:
- All enables = 0, pc_en=0, all clr=1.
- Overrides both `br` and `lu`; neither is counted on such cycles.

State machine (state held in flops):
- RUN: hazard logic as above.
  - wb_halt=1 → HALTED at the next edge.
  - In that same cycle the outputs are still computed normally, so the halting instruction's WB write completes.
- HALTED: all enables 0, pc_en 0, all clr 1, halted=1, hazard inputs ignored.
  - resume=1 → RESUME.
- RESUME (exactly one cycle): all enables 1, pc_en 1.
  - dm_wb_clr=0, which removes the stale halt from DM/WB.
  - wb_halt is ignored in this state.
  - Hazard logic is applied as in RUN, except that dm_busy freezes all stages except DM/WB.
  - Always → RUN at the next edge.
- resume while in RUN or RESUME is ignored.

Counters (all wrap modulo 2^CNT_W, no saturation):
- cycle_cnt: +1 on every edge while the state is not HALTED.
- stall_cnt: +1 on every edge where the `lu` pattern was applied.
- flush_cnt: +1 on every edge where the `br` pattern was applied.

## Timing
- All control outputs are combinational from the current inputs and the current state, with zero-cycle latency, so they are valid before the edge they act on.
- State and counters change only on posedge clk or on rst.
- While rst=1 (asynchronous):
  - state = RUN;
  - counters = 0;
  - all enables 0, all clr 0, pc_en 0, if_id_stall 0, halted 0.
- First edge after rst deasserts: default RUN behaviour.
- A load-use stall lasts exactly one cycle; on the following cycle the load has moved to DM, so `lu` is 0.
- rst asserted mid-stall, mid-freeze or in HALTED: immediate return to the reset values above; no pending events survive.
- wb_halt and dm_busy in the same RUN cycle: HALTED is entered at the edge, and the cycle's outputs follow the dm_busy pattern.

## Test plan
- Load-use: lw $3 in EX (ex_mem_read=1, ex_req_w=3); ID has id_rs=3, id_uses_rs=1.
  - Required: that cycle pc_en=0, if_id_stall=1, id_ex_clr=0; stall_cnt 0→1.
  - Required: next cycle all defaults.
  - Repeat with ex_req_w=0: no stall.
- Branch beats hazard: ex_branch_taken=1 and `lu` true together.
  - Required: if_id_clr=0, id_ex_clr=0, pc_en=1; flush_cnt +1, stall_cnt unchanged.
- Memory wait: dm_busy=1 for 3 cycles with br=1.
  - Required: all enables 0 for 3 cycles; flush_cnt unchanged; cycle_cnt +3.
- Halt/resume:
  - wb_halt=1 → next cycle halted=1, all enables 0, cycle_cnt frozen for 5 cycles.
  - resume pulse → one cycle with dm_wb_clr=0 and enables 1, then RUN with halted=0.
- Counter wrap (CNT_W=4): run 17 unhalted cycles from reset; required cycle_cnt=1.
- Async reset: assert rst between clock edges while in HALTED.
  - Required: halted drops immediately; counters 0; enables 0 and clr 0 until deassertion.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Stage-register enable/clear/stall and PC-enable control for
//               the 5-stage core. Resolves load-use bubbles, taken-branch
//               flushes and data-memory freezes. Also runs the RUN/HALTED/
//               RESUME halt sequencer and keeps cycle/stall/flush counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_req_w,
    input  logic             ex_branch_taken,
    input  logic             dm_busy,
    input  logic             wb_halt,
    input  logic             resume,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_dm_en,
    output logic             dm_wb_en,
    output logic             if_id_clr,
    output logic             id_ex_clr,
    output logic             ex_dm_clr,
    output logic             dm_wb_clr,
    output logic             if_id_stall,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_RESUME = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic              lu;
    logic              stall_applied;
    logic              flush_applied;

    // Load-use: a load in EX writes a register the ID instruction reads ($0 never hazards)
    always_comb begin
        lu = ex_mem_read && (ex_req_w != 5'd0) &&
             ((id_uses_rs && (id_rs == ex_req_w)) ||
              (id_uses_rt && (id_rt == ex_req_w)));
    end

    // Next state and per-stage control pattern; priority dm_busy > branch > load-use
    always_comb begin
        state_d       = state_q;
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        id_ex_en      = 1'b1;
        ex_dm_en      = 1'b1;
        dm_wb_en      = 1'b1;
        if_id_clr     = 1'b1;
        id_ex_clr     = 1'b1;
        ex_dm_clr     = 1'b1;
        dm_wb_clr     = 1'b1;
        if_id_stall   = 1'b0;
        halted        = 1'b0;
        stall_applied = 1'b0;
        flush_applied = 1'b0;

        case (state_q)
            ST_RUN, ST_RESUME: begin
                if (state_q == ST_RUN) begin
                    // Outputs stay normal this cycle so the halting write-back completes
                    if (wb_halt) begin
                        state_d = ST_HALTED;
                    end
                end else begin
                    // Single-cycle state: flush the stale halt out of DM/WB
                    state_d   = ST_RUN;
                    dm_wb_clr = 1'b0;
                end

                if (dm_busy) begin
                    pc_en    = 1'b0;
                    if_id_en = 1'b0;
                    id_ex_en = 1'b0;
                    ex_dm_en = 1'b0;
                    // DM/WB must still load its clear while resuming
                    dm_wb_en = (state_q == ST_RESUME);
                end else if (ex_branch_taken) begin
                    if_id_clr     = 1'b0;
                    id_ex_clr     = 1'b0;
                    flush_applied = 1'b1;
                end else if (lu) begin
                    pc_en         = 1'b0;
                    if_id_stall   = 1'b1;
                    id_ex_clr     = 1'b0;
                    stall_applied = 1'b1;
                end
            end
            ST_HALTED: begin
                pc_en    = 1'b0;
                if_id_en = 1'b0;
                id_ex_en = 1'b0;
                ex_dm_en = 1'b0;
                dm_wb_en = 1'b0;
                halted   = 1'b1;
                if (resume) begin
                    state_d = ST_RESUME;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        // While reset is held every control is forced inactive, clears asserted
        if (rst) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_dm_en      = 1'b0;
            dm_wb_en      = 1'b0;
            if_id_clr     = 1'b0;
            id_ex_clr     = 1'b0;
            ex_dm_clr     = 1'b0;
            dm_wb_clr     = 1'b0;
            if_id_stall   = 1'b0;
            halted        = 1'b0;
            stall_applied = 1'b0;
            flush_applied = 1'b0;
        end
    end

    // Performance counters wrap naturally; cycles do not count while halted
    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (state_q != ST_HALTED) begin
            cycle_cnt_d = cycle_cnt_q + 1'b1;
        end
        if (stall_applied) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (flush_applied) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    // State and counter registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            cycle_cnt_q <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cycle_cnt_q <= cycle_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_ctrl
// Description : Directed-vector bench for pipeline_hazard_ctrl (CNT_W = 4).
//               Each vector queues its expected control pattern and counter
//               values; a monitor compares them against the DUT mid-cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W = 4;

    // Pattern: {if_id_en,id_ex_en,ex_dm_en,dm_wb_en, if_id_clr,id_ex_clr,ex_dm_clr,dm_wb_clr, pc_en, if_id_stall, halted}
    localparam logic [10:0] P_DEF    = {4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0};
    localparam logic [10:0] P_LU     = {4'b1111, 4'b1011, 1'b0, 1'b1, 1'b0};
    localparam logic [10:0] P_BR     = {4'b1111, 4'b0011, 1'b1, 1'b0, 1'b0};
    localparam logic [10:0] P_FRZ    = {4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0};
    localparam logic [10:0] P_HLT    = {4'b0000, 4'b1111, 1'b0, 1'b0, 1'b1};
    localparam logic [10:0] P_RSM    = {4'b1111, 4'b1110, 1'b1, 1'b0, 1'b0};
    localparam logic [10:0] P_RSMFRZ = {4'b0001, 4'b1110, 1'b0, 1'b0, 1'b0};
    localparam logic [10:0] P_RSMBR  = {4'b1111, 4'b0010, 1'b1, 1'b0, 1'b0};
    localparam logic [10:0] P_RST    = {4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0};

    logic             clk;
    logic             rst;
    logic [4:0]       id_rs, id_rt, ex_req_w;
    logic             id_uses_rs, id_uses_rt, ex_mem_read;
    logic             ex_branch_taken, dm_busy, wb_halt, resume;
    logic             pc_en, if_id_en, id_ex_en, ex_dm_en, dm_wb_en;
    logic             if_id_clr, id_ex_clr, ex_dm_clr, dm_wb_clr;
    logic             if_id_stall, halted;
    logic [CNT_W-1:0] cycle_cnt, stall_cnt, flush_cnt;

    pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rs      (id_uses_rs),
        .id_uses_rt      (id_uses_rt),
        .ex_mem_read     (ex_mem_read),
        .ex_req_w        (ex_req_w),
        .ex_branch_taken (ex_branch_taken),
        .dm_busy         (dm_busy),
        .wb_halt         (wb_halt),
        .resume          (resume),
        .pc_en           (pc_en),
        .if_id_en        (if_id_en),
        .id_ex_en        (id_ex_en),
        .ex_dm_en        (ex_dm_en),
        .dm_wb_en        (dm_wb_en),
        .if_id_clr       (if_id_clr),
        .id_ex_clr       (id_ex_clr),
        .ex_dm_clr       (ex_dm_clr),
        .dm_wb_clr       (dm_wb_clr),
        .if_id_stall     (if_id_stall),
        .halted          (halted),
        .cycle_cnt       (cycle_cnt),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [10:0]      pat;
        logic [CNT_W-1:0] cyc;
        logic [CNT_W-1:0] st;
        logic [CNT_W-1:0] fl;
        int               id;
    } exp_t;

    exp_t             sb[$];
    int               n_total = 0;
    int               n_pass  = 0;
    int               vec_id  = 0;
    logic [CNT_W-1:0] exp_cyc = '0;
    logic [CNT_W-1:0] exp_st  = '0;
    logic [CNT_W-1:0] exp_fl  = '0;

    // Queue the expected view for this cycle, then advance counters for its edge
    task automatic vec(input logic [10:0] pat, input bit ci, input bit si, input bit fi);
        exp_t e;
        e.pat = pat;
        e.cyc = exp_cyc;
        e.st  = exp_st;
        e.fl  = exp_fl;
        e.id  = vec_id;
        vec_id++;
        sb.push_back(e);
        if (ci) exp_cyc = exp_cyc + 1'b1;
        if (si) exp_st  = exp_st + 1'b1;
        if (fi) exp_fl  = exp_fl + 1'b1;
    endtask

    task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                          input logic urt, input logic mr, input logic [4:0] rw,
                          input logic br, input logic busy, input logic hlt, input logic res);
        id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
        ex_mem_read = mr; ex_req_w = rw; ex_branch_taken = br;
        dm_busy = busy; wb_halt = hlt; resume = res;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare one queued expectation per cycle on the falling edge
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            logic [10:0] act;
            e   = sb.pop_front();
            act = {if_id_en, id_ex_en, ex_dm_en, dm_wb_en,
                   if_id_clr, id_ex_clr, ex_dm_clr, dm_wb_clr,
                   pc_en, if_id_stall, halted};
            n_total++;
            if (act === e.pat) n_pass++;
            else $display("FAIL ctrl vec%0d: got %b expected %b", e.id, act, e.pat);
            n_total++;
            if ({cycle_cnt, stall_cnt, flush_cnt} === {e.cyc, e.st, e.fl}) n_pass++;
            else $display("FAIL cnt vec%0d: got cyc=%0d st=%0d fl=%0d expected cyc=%0d st=%0d fl=%0d",
                          e.id, cycle_cnt, stall_cnt, flush_cnt, e.cyc, e.st, e.fl);
        end
    end

    initial begin
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        vec(P_RST, 0, 0, 0);
        nxt();
        rst = 1'b0;

        // 17 unhalted cycles from reset: 4-bit cycle counter wraps to 1
        for (int i = 0; i < 17; i++) begin
            vec(P_DEF, 1, 0, 0); nxt();
        end

        // Load-use on rs, then default the following cycle
        set_in(3, 0, 1, 0, 1, 3, 0, 0, 0, 0); vec(P_LU,  1, 1, 0); nxt();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); vec(P_DEF, 1, 0, 0); nxt();
        // Load to $0 never stalls
        set_in(0, 0, 1, 1, 1, 0, 0, 0, 0, 0); vec(P_DEF, 1, 0, 0); nxt();
        // Load-use on rt
        set_in(1, 5, 1, 1, 1, 5, 0, 0, 0, 0); vec(P_LU,  1, 1, 0); nxt();
        // Matching number but not read; matching but not a load
        set_in(7, 0, 0, 0, 1, 7, 0, 0, 0, 0); vec(P_DEF, 1, 0, 0); nxt();
        set_in(7, 0, 1, 0, 0, 7, 0, 0, 0, 0); vec(P_DEF, 1, 0, 0); nxt();
        // Branch beats load-use; branch alone
        set_in(3, 0, 1, 0, 1, 3, 1, 0, 0, 0); vec(P_BR,  1, 0, 1); nxt();
        set_in(0, 0, 0, 0, 0, 0, 1, 0, 0, 0); vec(P_BR,  1, 0, 1); nxt();
        // Memory wait for 3 cycles with branch and load-use present
        for (int i = 0; i < 3; i++) begin
            set_in(3, 0, 1, 0, 1, 3, 1, 1, 0, 0); vec(P_FRZ, 1, 0, 0); nxt();
        end
        // Resume in RUN is ignored
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); vec(P_DEF, 1, 0, 0); nxt();

        // Halt, 5 frozen cycles with hazards ignored, resume, RESUME, RUN
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); vec(P_DEF, 1, 0, 0); nxt();
        for (int i = 0; i < 5; i++) begin
            set_in(3, 0, 1, 0, 1, 3, 1, 1, 1, 0); vec(P_HLT, 0, 0, 0); nxt();
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1); vec(P_HLT, 0, 0, 0); nxt();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); vec(P_RSM, 1, 0, 0); nxt();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); vec(P_DEF, 1, 0, 0); nxt();

        // Halt together with dm_busy; RESUME with dm_busy keeps DM/WB moving
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 1, 0); vec(P_FRZ,    1, 0, 0); nxt();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); vec(P_HLT,    0, 0, 0); nxt();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1); vec(P_HLT,    0, 0, 0); nxt();
        set_in(0, 0, 0, 0, 0, 0, 1, 1, 1, 0); vec(P_RSMFRZ, 1, 0, 0); nxt();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); vec(P_DEF,    1, 0, 0); nxt();

        // RESUME with a taken branch: flush plus DM/WB clear
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); vec(P_DEF,   1, 0, 0); nxt();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1); vec(P_HLT,   0, 0, 0); nxt();
        set_in(0, 0, 0, 0, 0, 0, 1, 0, 1, 0); vec(P_RSMBR, 1, 0, 1); nxt();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); vec(P_DEF,   1, 0, 0); nxt();

        // Asynchronous reset between edges while HALTED
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); vec(P_DEF, 1, 0, 0); nxt();
        vec(P_HLT, 0, 0, 0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        exp_cyc = '0; exp_st = '0; exp_fl = '0;
        vec(P_RST, 0, 0, 0); nxt();
        vec(P_RST, 0, 0, 0); nxt();
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vec(P_DEF, 1, 0, 0); nxt();
        vec(P_DEF, 1, 0, 0); nxt();

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            n_total++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
